stream_bram_writer: RTL and testbench
=====================================

STREAM_BRAM_WRITER -- requirements
Module: stream_bram_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 1024, BRAM word width in bits.
REQ-002 SHALL have parameter IN_W, default 128, stream beat width in bits; LANES = DATA_W/IN_W = 8.
REQ-003 SHALL have parameter ADDR_W, default 13, BRAM word-address width.
REQ-004 SHALL have parameter DEPTH, default 5530, BRAM depth in words.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a transfer.
REQ-008 SHALL have port base_addr, input, ADDR_W, first BRAM word address, sampled on start.
REQ-009 SHALL have port num_words, input, ADDR_W+1, maximum number of words to write, sampled on start.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, IN_W) and in_eop (input, 1), forming the Avalon-ST sink.
REQ-011 SHALL have ports address (output, ADDR_W), chipselect (output, 1), write (output, 1), byteenable (output, DATA_W/8) and writedata (output, DATA_W), forming the BRAM write port; the port has no waitrequest.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), words_written (output, ADDR_W+1) and eop_seen (output, 1).

Function
REQ-013 SHALL implement states IDLE, PACK, WRITE and DONE.
REQ-014 In IDLE, start SHALL latch base_addr and num_words; the next state SHALL be DONE when num_words = 0, otherwise PACK; words_written and eop_seen SHALL clear.
REQ-015 A base_addr >= DEPTH SHALL be replaced by 0 when latched.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in PACK, decoded from state alone, never from in_valid.
REQ-018 In PACK, a beat is accepted when in_valid & in_ready; it SHALL be written into lane beat_cnt (lane 0 = bits IN_W-1:0), and beat_cnt SHALL increment.
REQ-019 PACK SHALL go to WRITE in the cycle after the 8th accepted beat or after an accepted beat with in_eop, whichever occurs first.
REQ-020 WRITE SHALL last exactly one cycle, with chipselect = write = 1, address = current address and writedata = packed word.
REQ-021 byteenable SHALL set IN_W/8 bits for each filled lane and clear them for each unfilled lane; unfilled lanes of writedata SHALL be 0.
REQ-022 After WRITE: words_written SHALL increment, the address SHALL increment and wrap from DEPTH-1 to 0, and beat_cnt and lane data SHALL clear.
REQ-023 The state after WRITE SHALL be DONE when the written word held eop or words_written reaches num_words, otherwise PACK.
REQ-024 When eop is accepted, eop_seen SHALL set and hold until the next start.
REQ-025 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-026 busy SHALL be 1 in PACK, WRITE and DONE.
REQ-027 Outside WRITE, chipselect, write and byteenable SHALL be 0.
REQ-028 Sustained throughput SHALL be 8 beats plus 1 write cycle, i.e. 9 cycles per full word.

Reset
REQ-029 Reset SHALL force IDLE and zero all outputs, counters, lane data and latched parameters.
REQ-030 Reset mid-transfer SHALL abandon any partial word without writing it; no write SHALL be issued in the reset cycle.
REQ-031 Reset SHALL take priority over start.

Structure
REQ-032 Package stream_bram_pkg SHALL hold DATA_W, IN_W, LANES, ADDR_W, DEPTH and the state enum.
REQ-033 The design SHALL be a single module with no sub-module; lane packing is a lane-indexed register array inside it.

Verification
REQ-034 Start with base 0 and num_words 2, then 16 beats of data 1..16 with eop on beat 16 -> writes at address 0 (lanes = 1..8) and address 1 (lanes = 9..16), each with byteenable all-ones; done pulses; words_written = 2; eop_seen = 1.
REQ-035 Start with num_words 4, then 3 beats with eop on beat 3 -> one write of byteenable 0x...0000_FFFF_FFFF_FFFF (48 bits set) with lanes 3..7 = 0; done pulses; words_written = 1.
REQ-036 Start with base 5529 and num_words 3, then 24 beats -> writes at addresses 5529, 0 and 1; done pulses after the third write; eop_seen = 0.
REQ-037 in_valid toggled randomly at 50% with num_words 1 -> exactly one write with correct lane order; in_ready stays 1 throughout PACK.
REQ-038 Reset after 5 beats -> no write issued; busy = 0 the next cycle; a fresh start with 8 beats writes to the newly latched base.
REQ-039 Start with num_words 0 -> done pulses 2 cycles after start; no write; in_ready never asserts.

Source files
------------

// File: rtl/stream_bram_pkg.sv
// stream_bram_pkg
// Shared constants and the controller state type for the stream-to-BRAM
// writer. The stream beats are packed into wide BRAM words, LANES beats per word.
package stream_bram_pkg;

  localparam int DATA_W = 1024;          // BRAM word width
  localparam int IN_W   = 128;           // stream beat width
  localparam int LANES  = DATA_W / IN_W; // beats per BRAM word
  localparam int ADDR_W = 13;            // BRAM word-address width
  localparam int DEPTH  = 5530;          // BRAM depth in words

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stream_bram_writer_if.sv
// stream_bram_writer_if
// Bundles the Avalon-ST sink (in_valid/in_ready/in_data/in_eop) and the
// BRAM write port (address/chipselect/write/byteenable/writedata).
//   slave  : the writer itself (consumes the stream, drives the BRAM port)
//   master : the environment (drives the stream, observes the BRAM port)
interface stream_bram_writer_if #(
  parameter int DATA_W = stream_bram_pkg::DATA_W,
  parameter int IN_W   = stream_bram_pkg::IN_W,
  parameter int ADDR_W = stream_bram_pkg::ADDR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  in_eop;

  logic [ADDR_W-1:0]     address;
  logic                  chipselect;
  logic                  write;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;

  modport slave (
    input  in_valid, in_data, in_eop,
    output in_ready, address, chipselect, write, byteenable, writedata
  );

  modport master (
    output in_valid, in_data, in_eop,
    input  in_ready, address, chipselect, write, byteenable, writedata
  );

endinterface

// File: rtl/stream_bram_writer.sv
// stream_bram_writer
// Packs IN_W-bit stream beats into DATA_W-bit BRAM words and writes them to
// consecutive addresses starting at a latched base, wrapping at DEPTH.
// A word is written after LANES beats or after a beat carrying eop,
// whichever comes first; a transfer ends on eop or after num_words words.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse, honoured only while idle
//   base_addr         : first word address (latched on start, >= DEPTH -> 0)
//   num_words         : word limit for the transfer (latched on start)
//   bus               : stream sink + BRAM write port (slave modport)
//   busy              : transfer in progress
//   done              : one-cycle completion pulse
//   words_written     : words written in the current/last transfer
//   eop_seen          : eop accepted in the current/last transfer
module stream_bram_writer #(
  parameter int DATA_W = stream_bram_pkg::DATA_W,
  parameter int IN_W   = stream_bram_pkg::IN_W,
  parameter int ADDR_W = stream_bram_pkg::ADDR_W,
  parameter int DEPTH  = stream_bram_pkg::DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      num_words,
  stream_bram_writer_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      words_written,
  output logic                 eop_seen
);

  import stream_bram_pkg::*;

  localparam int LANES  = DATA_W / IN_W;
  localparam int LANE_B = IN_W / 8;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int LIDX_W = $clog2(LANES);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     num_q;
  logic [ADDR_W:0]     words_q;
  logic [CNT_W-1:0]    beat_cnt;
  logic [IN_W-1:0]     lane_q [LANES];
  logic                word_eop;   // the word being packed closed on eop
  logic                eop_seen_q;
  logic                done_q;
  logic                accept;
  logic                wr;

  assign accept = (state == PACK) && bus.in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_words == '0) ? DONE : PACK;
      PACK:    if (accept && ((beat_cnt == CNT_W'(LANES - 1)) || bus.in_eop))
                 state_nxt = WRITE;
      WRITE:   state_nxt = (word_eop || ((words_q + 1'b1) == num_q)) ? DONE : PACK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      num_q      <= '0;
      words_q    <= '0;
      beat_cnt   <= '0;
      word_eop   <= 1'b0;
      eop_seen_q <= 1'b0;
      done_q     <= 1'b0;
      for (int l = 0; l < LANES; l++) lane_q[l] <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            addr_q     <= (base_addr >= DEPTH_A) ? '0 : base_addr;
            num_q      <= num_words;
            words_q    <= '0;
            eop_seen_q <= 1'b0;
          end
        end
        PACK: begin
          if (accept) begin
            lane_q[beat_cnt[LIDX_W-1:0]] <= bus.in_data;
            beat_cnt <= beat_cnt + 1'b1;
            if (bus.in_eop) begin
              word_eop   <= 1'b1;
              eop_seen_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          words_q  <= words_q + 1'b1;
          addr_q   <= (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
          beat_cnt <= '0;
          word_eop <= 1'b0;
          for (int l = 0; l < LANES; l++) lane_q[l] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so a reset landing in the WRITE cycle suppresses the write.
  assign wr = (state == WRITE) && !reset;

  always_comb begin
    bus.byteenable = '0;
    bus.writedata  = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.writedata[l*IN_W +: IN_W] = lane_q[l];
      if (wr && (CNT_W'(l) < beat_cnt)) bus.byteenable[l*LANE_B +: LANE_B] = '1;
    end
  end

  assign bus.chipselect = wr;
  assign bus.write      = wr;
  assign bus.address    = addr_q;
  assign bus.in_ready   = (state == PACK);
  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign words_written  = words_q;
  assign eop_seen       = eop_seen_q;

endmodule

// File: tb/tb_stream_bram_writer.sv
// tb_stream_bram_writer
// Drives directed and randomized transfers into stream_bram_writer. A
// reference model turns each transfer's beat list into the list of BRAM
// writes it must produce; a monitor compares every write (and every idle
// cycle) against that list. Literal expectations pin the model on the
// directed cases.
module tb_stream_bram_writer;

  localparam int DW = 1024;
  localparam int IW = 128;
  localparam int AW = 13;
  localparam int DP = 5530;
  localparam int LN = DW / IW;

  typedef struct {
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [DW/8-1:0] be;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy, done, eop_seen;
  logic [AW:0]   words_written;

  stream_bram_writer_if #(.DATA_W(DW), .IN_W(IW), .ADDR_W(AW)) bus ();

  stream_bram_writer #(.DATA_W(DW), .IN_W(IW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .bus           (bus.slave),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .eop_seen      (eop_seen)
  );

  always #5 clk = ~clk;

  wr_t              exp_q[$];
  wr_t              cap_q[$];
  logic [IW-1:0]    beats[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               done_cnt = 0;
  int               m_words;
  bit               m_eop;

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle out of reset, either a write that must match the
  // next expected word, or an idle BRAM port.
  always @(negedge clk) begin : mon
    wr_t w, e;
    if (!reset) begin
      if (bus.write) begin
        w.a = bus.address; w.d = bus.writedata; w.be = bus.byteenable;
        cap_q.push_back(w);
        chk("wr_cs", 128'(bus.chipselect), 128'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", 128'(bus.address), 128'h1_0000);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 128'(w.a), 128'(e.a));
          for (int l = 0; l < LN; l++) chk($sformatf("wr_lane%0d", l), w.d[l*IW +: IW], e.d[l*IW +: IW]);
          chk("wr_be", w.be, e.be);
        end
      end else begin
        chk("idle_port", {126'd0, bus.chipselect, |bus.byteenable}, 128'd0);
      end
      chk("ready_implies_busy", 128'(bus.in_ready & ~busy), 128'd0);
      if (done) done_cnt++;
    end
  end

  // Reference model: group beats into words of LN lanes, closing a word early
  // on eop; stop on eop or after nw words. Addresses wrap modulo DP.
  task automatic model(input int base, input int nw, input bit eop_last);
    int a, lane;
    bit last;
    wr_t w;
    a = (base >= DP) ? 0 : base;
    lane = 0; w.d = '0; w.be = '0; m_words = 0; m_eop = 0;
    if (nw == 0) return;
    for (int i = 0; i < beats.size(); i++) begin
      w.d[lane*IW +: IW] = beats[i];
      w.be[lane*(IW/8) +: IW/8] = '1;
      lane++;
      last = eop_last && (i == beats.size() - 1);
      if (last) m_eop = 1;
      if (lane == LN || last) begin
        w.a = AW'(a);
        exp_q.push_back(w);
        a = (a + 1) % DP;
        m_words++;
        lane = 0; w.d = '0; w.be = '0;
        if (last || m_words == nw) break;
      end
    end
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input bit e, input bit rnd, input bit chk_rdy);
    int t = 0;
    int idle = 0;
    if (rnd) begin
      while (idle < 20 && $urandom_range(1, 0) == 1) begin
        bus.in_valid = 1'b0;
        if (chk_rdy) chk("ready_hold_in_pack", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #1;
        idle++;
      end
    end
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_eop = e;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("beat_accept_timeout", 128'(t), 128'd0);
    else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_eop = 1'b0;
  endtask

  task automatic pulse_start(input int base, input int nw);
    base_addr = AW'(base); num_words = (AW+1)'(nw); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One full transfer: beats 1..n (seq) or random data, then wait for done
  // and check the end-of-transfer status against the model.
  task automatic run(input int base, input int nw, input int nb, input bit eop_last,
                     input bit seq, input bit rnd, input bit chk_rdy);
    int d0, t;
    beats.delete();
    cap_q.delete();
    for (int i = 0; i < nb; i++)
      beats.push_back(seq ? IW'(i + 1) : {$urandom, $urandom, $urandom, $urandom});
    model(base, nw, eop_last);
    pulse_start(base, nw);
    d0 = done_cnt;
    for (int i = 0; i < nb; i++) send_beat(beats[i], eop_last && (i == nb - 1), rnd, chk_rdy);
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 128'(done_cnt - d0), 128'd1);
    chk("writes_outstanding", 128'(exp_q.size()), 128'd0);
    chk("words_written", 128'(words_written), 128'(m_words));
    chk("eop_seen", 128'(eop_seen), 128'(m_eop));
    chk("busy_after_done", 128'(busy), 128'd0);
    exp_q.delete();
  endtask

  initial begin
    int nw, nb, base;
    bit el;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_words", 128'(words_written), 128'd0);
    chk("rst_eop", 128'(eop_seen), 128'd0);
    chk("rst_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_strobes", {125'd0, bus.write, bus.chipselect, |bus.byteenable}, 128'd0);
    chk("rst_addr", 128'(bus.address), 128'd0);
    chk("rst_wdata", 128'(|bus.writedata), 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Two full words, eop on the last beat.
    run(0, 2, 16, 1, 1, 0, 0);
    chk("t1_nwr", 128'(cap_q.size()), 128'd2);
    if (cap_q.size() == 2) begin
      chk("t1_a0", 128'(cap_q[0].a), 128'd0);
      chk("t1_w0_l0", cap_q[0].d[IW-1:0], 128'd1);
      chk("t1_w0_l7", cap_q[0].d[DW-1:DW-IW], 128'd8);
      chk("t1_a1", 128'(cap_q[1].a), 128'd1);
      chk("t1_w1_l0", cap_q[1].d[IW-1:0], 128'd9);
      chk("t1_w1_l7", cap_q[1].d[DW-1:DW-IW], 128'd16);
      chk("t1_be1", cap_q[1].be, {128{1'b1}});
    end
    chk("t1_words", 128'(words_written), 128'd2);
    chk("t1_eop", 128'(eop_seen), 128'd1);

    // Short word closed by eop after 3 beats.
    run(0, 4, 3, 1, 1, 0, 0);
    chk("t2_nwr", 128'(cap_q.size()), 128'd1);
    if (cap_q.size() == 1) begin
      chk("t2_be", cap_q[0].be, 128'h0000_0000_0000_0000_0000_FFFF_FFFF_FFFF);
      chk("t2_l2", cap_q[0].d[3*IW-1:2*IW], 128'd3);
      chk("t2_hi_zero", 128'(|cap_q[0].d[DW-1:3*IW]), 128'd0);
    end
    chk("t2_words", 128'(words_written), 128'd1);

    // Address wrap at the top of the BRAM.
    run(5529, 3, 24, 0, 1, 0, 0);
    chk("t3_nwr", 128'(cap_q.size()), 128'd3);
    if (cap_q.size() == 3) begin
      chk("t3_a0", 128'(cap_q[0].a), 128'd5529);
      chk("t3_a1", 128'(cap_q[1].a), 128'd0);
      chk("t3_a2", 128'(cap_q[2].a), 128'd1);
    end
    chk("t3_eop", 128'(eop_seen), 128'd0);

    // Out-of-range base falls back to address 0.
    run(6000, 1, 8, 0, 0, 0, 0);
    if (cap_q.size() == 1) chk("t4_a0", 128'(cap_q[0].a), 128'd0);
    else chk("t4_nwr", 128'(cap_q.size()), 128'd1);

    // Random in_valid gaps; in_ready must hold high while packing.
    run(123, 1, 8, 0, 0, 1, 1);
    chk("t5_nwr", 128'(cap_q.size()), 128'd1);

    // Reset part-way through a word: nothing written, then a clean restart.
    cap_q.delete();
    beats.delete();
    pulse_start(7, 3);
    for (int i = 0; i < 5; i++) send_beat(IW'(i + 100), 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_busy", 128'(busy), 128'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_nwr", 128'(cap_q.size()), 128'd0);
    run(200, 1, 8, 0, 0, 0, 0);
    if (cap_q.size() == 1) chk("t6_a0", 128'(cap_q[0].a), 128'd200);
    else chk("t6_nwr2", 128'(cap_q.size()), 128'd1);

    // Zero-word transfer: done two cycles after start, no write, no ready.
    cap_q.delete();
    pulse_start(50, 0);
    chk("t7_c1_done", 128'(done), 128'd0);
    chk("t7_c1_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk); #1;
    chk("t7_c2_done", 128'(done), 128'd1);
    chk("t7_c2_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk); #1;
    chk("t7_c3_done", 128'(done), 128'd0);
    chk("t7_nwr", 128'(cap_q.size()), 128'd0);
    chk("t7_words", 128'(words_written), 128'd0);

    // Randomized transfers.
    for (int k = 0; k < 8; k++) begin
      base = $urandom_range(DP - 1, 0);
      nw = $urandom_range(3, 1);
      nb = $urandom_range(nw * LN, 1);
      el = (nb < nw * LN) ? 1'b1 : 1'($urandom_range(1, 0));
      run(base, nw, nb, el, 0, 1'($urandom_range(1, 0)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
